mu_afeser: RTL and testbench

MU_AFESER -- requirements
Module: mu_afeser

---
 rtl/mu_afeser.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mu_afeser.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_afeser.sv
// APB-programmed serial frame engine for an AFE: a word FIFO feeds an LSB-first
// shifter driving sck/sdata/sl, plus a programmable-width sync pulse.
module mu_afeser #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_apb_paddr,
    input  logic        s_apb_psel,
    input  logic        s_apb_penable,
    input  logic        s_apb_pwrite,
    input  logic [31:0] s_apb_pwdata,
    output logic        s_apb_pready,
    output logic [31:0] s_apb_prdata,
    output logic        afe_rst,
    output logic        afe_sync,
    output logic        afe_sdata,
    output logic        afe_sl,
    output logic        afe_sck,
    output logic        irq
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SCK_HI = 3'd2,
        SCK_LO = 3'd3,
        LATCH  = 3'd4,
        SYNC   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_rst_lvl;
    logic             r_sync_req;
    logic [DIV_W-1:0] r_div_cfg;
    logic [4:0]       r_len_cfg;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W:0]   r_hcnt;
    logic [5:0]       r_bits;
    logic [31:0]      r_shift;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [4:0]       r_level;
    logic             r_ovf;
    logic             r_sck;
    logic             r_sdata;
    logic             r_sl;
    logic             r_sync;
    logic             r_irq;
    logic [31:0]      r_prdata;

    logic        w_acc, w_wr, w_rd;
    logic [1:0]  w_sel;
    logic        w_wr_ctrl, w_wr_stat, w_wr_tx;
    logic        w_full, w_empty, w_busy;
    logic        w_push, w_pop, w_ovf_evt;
    logic        w_tick, w_sync_done, w_shifting;
    logic [DIV_W:0] w_lim;
    logic [31:0] w_shift_nx;
    logic [4:0]  w_level_nx;
    logic        w_ovf_nx;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_rd_data;
    logic        w_unused_addr;

    assign w_acc     = s_apb_psel & s_apb_penable;
    assign w_wr      = w_acc & s_apb_pwrite;
    assign w_rd      = w_acc & ~s_apb_pwrite;
    assign w_sel     = s_apb_paddr[3:2];
    assign w_wr_ctrl = w_wr & (w_sel == 2'd0);
    assign w_wr_stat = w_wr & (w_sel == 2'd1);
    assign w_wr_tx   = w_wr & (w_sel == 2'd2);
    assign w_unused_addr = ^{s_apb_paddr[31:4], s_apb_paddr[1:0]};

    assign w_full    = (r_level == DEPTH_L);
    assign w_empty   = (r_level == 5'd0);
    assign w_busy    = (r_state != IDLE);
    assign w_push    = w_wr_tx & ~w_full;
    assign w_ovf_evt = w_wr_tx & w_full;

    // Sync holds for two half-periods, every other state for one.
    assign w_lim  = (r_state == SYNC) ? {r_div, 1'b1} : {1'b0, r_div};
    assign w_tick = (r_hcnt == w_lim);

    assign s_apb_pready = 1'b1;
    assign s_apb_prdata = r_prdata;
    assign afe_rst      = r_rst_lvl;
    assign afe_sync     = r_sync;
    assign afe_sdata    = r_sdata;
    assign afe_sl       = r_sl;
    assign afe_sck      = r_sck;
    assign irq          = r_irq;

    // Next-state decode; frames are held back while the AFE is kept in reset.
    always_comb begin
        w_state_nx  = r_state;
        w_pop       = 1'b0;
        w_sync_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync_req) begin
                    w_state_nx = SYNC;
                end else if (!w_empty && !r_rst_lvl) begin
                    w_pop      = 1'b1;
                    w_state_nx = SETUP;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            SETUP:  if (w_tick) w_state_nx = SCK_HI; else w_state_nx = SETUP;
            SCK_HI: if (w_tick) w_state_nx = SCK_LO; else w_state_nx = SCK_HI;
            SCK_LO: begin
                if (!w_tick) begin
                    w_state_nx = SCK_LO;
                end else if (r_bits != 6'd1) begin
                    w_state_nx = SCK_HI;
                end else begin
                    w_state_nx = LATCH;
                end
            end
            LATCH:  if (w_tick) w_state_nx = IDLE; else w_state_nx = LATCH;
            SYNC: begin
                if (w_tick) begin
                    w_state_nx  = IDLE;
                    w_sync_done = 1'b1;
                end else begin
                    w_state_nx = SYNC;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath next values: shifter, FIFO level, overflow flag and read mux.
    always_comb begin
        w_shift_nx = r_shift;
        w_level_nx = r_level;
        w_ovf_nx   = r_ovf;
        w_ctrl_rd  = 32'd0;
        w_rd_data  = 32'd0;
        if (w_pop) begin
            w_shift_nx = r_mem[r_rptr];
        end else if (r_state == SCK_HI && w_state_nx == SCK_LO) begin
            w_shift_nx = {1'b0, r_shift[31:1]};
        end else begin
            w_shift_nx = r_shift;
        end
        case ({w_push, w_pop})
            2'b10:   w_level_nx = r_level + 5'd1;
            2'b01:   w_level_nx = r_level - 5'd1;
            default: w_level_nx = r_level;
        endcase
        if (w_ovf_evt) begin
            w_ovf_nx = 1'b1;
        end else if (w_wr_stat && s_apb_pwdata[3]) begin
            w_ovf_nx = 1'b0;
        end else begin
            w_ovf_nx = r_ovf;
        end
        w_ctrl_rd[0]            = r_rst_lvl;
        w_ctrl_rd[1]            = r_sync_req;
        w_ctrl_rd[DIV_W+7:8]    = r_div_cfg;
        w_ctrl_rd[28:24]        = r_len_cfg;
        case (w_sel)
            2'd0:    w_rd_data = w_ctrl_rd;
            2'd1:    w_rd_data = {23'd0, r_level, r_ovf, w_empty, w_full, w_busy};
            default: w_rd_data = 32'd0;
        endcase
    end

    assign w_shifting = (w_state_nx == SETUP) || (w_state_nx == SCK_HI) ||
                        (w_state_nx == SCK_LO);

    // Control register and pending sync request; a new request wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_lvl  <= 1'b0;
            r_sync_req <= 1'b0;
            r_div_cfg  <= '0;
            r_len_cfg  <= 5'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_rst_lvl <= s_apb_pwdata[0];
                r_div_cfg <= s_apb_pwdata[DIV_W+7:8];
                r_len_cfg <= s_apb_pwdata[28:24];
            end
            if (w_wr_ctrl && s_apb_pwdata[1]) begin
                r_sync_req <= 1'b1;
            end else if (w_sync_done) begin
                r_sync_req <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; validity is tracked by level and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_apb_pwdata;
        end
    end

    // FIFO pointers, level and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= 5'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_level <= w_level_nx;
            r_ovf   <= w_ovf_nx;
        end
    end

    // Engine state; div and len are captured when a frame or sync pulse starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_hcnt  <= '0;
            r_bits  <= 6'd0;
            r_shift <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            if (r_state == IDLE && w_state_nx != IDLE) r_div <= r_div_cfg;
            if (r_state == IDLE || w_state_nx != r_state) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + (DIV_W+1)'(1);
            end
            if (w_pop) begin
                r_bits <= (r_len_cfg == 5'd0) ? 6'd32 : {1'b0, r_len_cfg};
            end else if (r_state == SCK_LO && w_state_nx == SCK_HI) begin
                r_bits <= r_bits - 6'd1;
            end
        end
    end

    // Pin, interrupt and read-data registers, driven from next-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck    <= 1'b0;
            r_sdata  <= 1'b0;
            r_sl     <= 1'b1;
            r_sync   <= 1'b0;
            r_irq    <= 1'b1;
            r_prdata <= 32'd0;
        end else begin
            r_sck    <= (w_state_nx == SCK_HI);
            r_sl     <= ~w_shifting;
            r_sdata  <= w_shifting ? w_shift_nx[0] : 1'b0;
            r_sync   <= (w_state_nx == SYNC);
            r_irq    <= ((w_level_nx == 5'd0) && (w_state_nx == IDLE)) || w_ovf_nx;
            r_prdata <= w_rd ? w_rd_data : 32'd0;
        end
    end
endmodule

// File: tb/tb_mu_afeser.sv
// Directed bench for mu_afeser: stimulus queues expected frames/sync pulses,
// a pin monitor decodes the serial lines and compares against that queue.
module tb_mu_afeser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic        pready;
    logic [31:0] prdata;
    logic        afe_rst, afe_sync, afe_sdata, afe_sl, afe_sck, irq;

    mu_afeser #(.FIFO_DEPTH(4), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
        .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pready(pready), .s_apb_prdata(prdata),
        .afe_rst(afe_rst), .afe_sync(afe_sync), .afe_sdata(afe_sdata),
        .afe_sl(afe_sl), .afe_sck(afe_sck), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_sync;
        logic [31:0] data;
        int          nbits;
        int          h;
    } ev_t;
    ev_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        d = prdata; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_rd(a, d);
        chk(name, d, exp);
    endtask

    // Queue the expected frame, then push the word through TXDATA.
    task automatic tx(input logic [31:0] w, input int n, input int h, input bit expect_frame);
        ev_t e;
        logic [31:0] mask;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        e.is_sync = 1'b0; e.data = w & mask; e.nbits = n; e.h = h;
        if (expect_frame) sb.push_back(e);
        apb_wr(32'h8, w);
    endtask

    task automatic exp_sync(input int h);
        ev_t e;
        e.is_sync = 1'b1; e.data = 32'd0; e.nbits = 0; e.h = h;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int lim);
        int c;
        c = 0;
        @(negedge clk);
        while (!irq && c < lim) begin
            c++;
            @(negedge clk);
        end
        chk(name, {31'd0, irq}, 32'd1);
    endtask

    // Count cycles irq stays low after a push that starts a frame into an empty FIFO.
    task automatic irq_low_len(input string name, input int exp);
        int c;
        c = 0;
        @(negedge clk);
        while (!irq && c < 2000) begin
            c++;
            @(negedge clk);
        end
        chk(name, 32'(c), 32'(exp));
    endtask

    // Pin monitor
    logic        m_in = 1'b0;
    logic        m_prev_sck = 1'b0;
    logic [31:0] m_cap;
    int m_nb, m_low, m_hi_run, m_lo_run, m_sync_cnt;
    int m_hi_min, m_hi_max, m_lo_min, m_lo_max;

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            m_in = 1'b0; m_sync_cnt = 0; m_prev_sck = 1'b0;
        end else begin
            if (afe_sync) begin
                m_sync_cnt++;
            end else if (m_sync_cnt != 0) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow_sync", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_sync", {31'd0, e.is_sync}, 32'd1);
                    chk("sync_len", 32'(m_sync_cnt), 32'(2 * e.h));
                end
                m_sync_cnt = 0;
            end
            if (!afe_sl) begin
                if (!m_in) begin
                    m_in = 1'b1; m_cap = 32'd0; m_nb = 0; m_low = 0;
                    m_hi_run = 0; m_lo_run = 0;
                    m_hi_min = 1000000; m_hi_max = 0; m_lo_min = 1000000; m_lo_max = 0;
                end
                m_low++;
                if (afe_sck) begin
                    if (!m_prev_sck) begin
                        if (m_lo_run < m_lo_min) m_lo_min = m_lo_run;
                        if (m_lo_run > m_lo_max) m_lo_max = m_lo_run;
                        m_lo_run = 0;
                        if (m_nb < 32) m_cap[m_nb] = afe_sdata;
                        m_nb++;
                    end
                    m_hi_run++;
                end else begin
                    if (m_prev_sck) begin
                        if (m_hi_run < m_hi_min) m_hi_min = m_hi_run;
                        if (m_hi_run > m_hi_max) m_hi_max = m_hi_run;
                        m_hi_run = 0;
                    end
                    m_lo_run++;
                end
            end else if (m_in) begin
                if (m_lo_run < m_lo_min) m_lo_min = m_lo_run;
                if (m_lo_run > m_lo_max) m_lo_max = m_lo_run;
                m_in = 1'b0;
                if (sb.size() == 0) begin
                    chk("sb_underflow_frame", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_frame", {31'd0, e.is_sync}, 32'd0);
                    chk("frame_bits", 32'(m_nb), 32'(e.nbits));
                    chk("frame_data", m_cap, e.data);
                    chk("sl_low_cycles", 32'(m_low), 32'((2 * e.nbits + 1) * e.h));
                    chk("sck_hi_width", {16'(m_hi_min), 16'(m_hi_max)}, {16'(e.h), 16'(e.h)});
                    chk("sck_lo_width", {16'(m_lo_min), 16'(m_lo_max)}, {16'(e.h), 16'(e.h)});
                end
            end
            m_prev_sck = afe_sck;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_sck;
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pins", {26'd0, afe_rst, afe_sync, afe_sdata, afe_sl, afe_sck, irq}, 32'h05);
        chk("reset_prdata", prdata, 32'd0);
        chk("pready", {31'd0, pready}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rd_chk("reset_status", 32'h4, 32'h0000_0004);
        rd_chk("reset_ctrl", 32'h0, 32'h0000_0000);
        @(posedge clk); #1;
        chk("prdata_idle_zero", prdata, 32'd0);

        // Test 6: rst_level and reserved register
        apb_wr(32'h0, 32'h0000_0001);
        chk("t6_afe_rst", {31'd0, afe_rst}, 32'd1);
        rd_chk("t6_ctrl", 32'h0, 32'h0000_0001);
        apb_wr(32'hC, 32'hFFFF_FFFF);
        rd_chk("t6_reserved", 32'hC, 32'h0000_0000);

        // Test 3: overflow while frames are held back, then W1C and drain
        for (int i = 0; i < 5; i++) tx(32'hC0DE_0000 + 32'(i * 32'h1111), 32, 1, i < 4);
        rd_chk("t3_status_ovf", 32'h4, 32'h0000_004A);
        @(negedge clk);
        chk("t3_irq_ovf", {31'd0, irq}, 32'd1);
        apb_wr(32'h4, 32'h0000_0008);
        rd_chk("t3_status_w1c", 32'h4, 32'h0000_0042);
        @(negedge clk);
        chk("t3_irq_cleared", {31'd0, irq}, 32'd0);
        apb_wr(32'h0, 32'h0000_0000);
        wait_idle("t3_drained", 2000);

        // Test 1: div=0, len=8, 0xA5
        apb_wr(32'h0, 32'h0800_0000);
        tx(32'h0000_00A5, 8, 1, 1'b1);
        irq_low_len("t1_frame_cycles", 1 + 18);

        // Test 2: div=3, len=32
        apb_wr(32'h0, 32'h0000_0300);
        tx(32'h8000_0001, 32, 4, 1'b1);
        irq_low_len("t2_frame_cycles", 1 + 264);

        // Test 4: sync requested mid-frame, new div/len only for later events
        apb_wr(32'h0, 32'h0400_0100);
        tx(32'h0000_000B, 4, 2, 1'b1);
        c = 0;
        @(negedge clk);
        while (afe_sl && c < 50) begin
            c++;
            @(negedge clk);
        end
        chk("t4_frame_started", {31'd0, afe_sl}, 32'd0);
        exp_sync(1);
        apb_wr(32'h0, 32'h0300_0002);
        tx(32'h0000_0006, 3, 1, 1'b1);
        wait_idle("t4_done", 500);
        rd_chk("t4_sync_cleared", 32'h0, 32'h0300_0000);
        chk("t4_sb_drained", 32'(sb.size()), 32'd0);

        // Test 5: reset during SCK_HI
        apb_wr(32'h0, 32'h0800_0300);
        tx(32'h0000_00FF, 8, 4, 1'b0);
        c = 0;
        @(negedge clk);
        while (!afe_sck && c < 100) begin
            c++;
            @(negedge clk);
        end
        chk("t5_sck_seen", {31'd0, afe_sck}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_pins", {26'd0, afe_rst, afe_sync, afe_sdata, afe_sl, afe_sck, irq}, 32'h05);
        chk("t5_async_prdata", prdata, 32'd0);
        any_sck = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_sck = any_sck | afe_sck;
        end
        chk("t5_no_sck_in_reset", {31'd0, any_sck}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rd_chk("t5_status_empty", 32'h4, 32'h0000_0004);
        rd_chk("t5_ctrl_cleared", 32'h0, 32'h0000_0000);
        repeat (5) @(negedge clk);
        chk("t5_sl_idle", {31'd0, afe_sl}, 32'd1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
